// File: rtl/fir_coeff_loader_pkg.sv
// Shared FIR types: tap count, coefficient width, bank layout and loader states.
// The FIR datapath imports coef_bank_t from here so both sides agree on packing.
package fir_pkg;

    localparam int NUMTAPS = 32;
    localparam int COEFW   = 16;
    localparam int CNTW    = (NUMTAPS > 1) ? $clog2(NUMTAPS) : 1;

    typedef logic signed [COEFW-1:0]       coef_t;
    typedef logic [NUMTAPS-1:0][COEFW-1:0] coef_bank_t;
    typedef logic [CNTW-1:0]               tap_idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } loader_state_t;

    localparam tap_idx_t LAST_TAP = tap_idx_t'(NUMTAPS - 1);

    function automatic logic state_is_busy(input loader_state_t s);
        return (s == LOAD) || (s == PENDING);
    endfunction

    function automatic logic state_accepts(input loader_state_t s);
        return (s == IDLE) || (s == LOAD);
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Valid/ready coefficient stream into the loader; word i of a frame targets tap i.
interface fir_coeff_loader_if
    import fir_pkg::*;
();

    logic  coef_valid;
    logic  coef_ready;
    coef_t coef_data;
    logic  coef_last;

    modport master (
        output coef_valid,
        output coef_data,
        output coef_last,
        input  coef_ready
    );

    modport slave (
        input  coef_valid,
        input  coef_data,
        input  coef_last,
        output coef_ready
    );

endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered coefficient loader: stream fills a shadow bank, a sample-aligned
// swap strobe commits the whole bank so the filter never sees a partial set.
//
//   state   | meaning
//   IDLE    | waiting for the first word of a frame
//   LOAD    | collecting words 1..NUMTAPS-1 into the shadow bank
//   PENDING | shadow bank complete, waiting for swap_en
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fir_coeff_loader_if.slave   coef_if,
    input  logic                load_abort,
    input  logic                swap_en,
    output coef_bank_t          coefficients,
    output logic                busy,
    output logic                load_done,
    output logic                load_err
);

    loader_state_t state_q, state_d;
    tap_idx_t      cnt_q,   cnt_d;
    coef_bank_t    shadow_q, shadow_d;
    coef_bank_t    active_q, active_d;
    logic          done_q,  done_d;
    logic          err_q,   err_d;
    logic          beat;

    assign coef_if.coef_ready = state_accepts(state_q);
    assign beat               = coef_if.coef_valid && coef_if.coef_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // Abort wins over any beat or swap in the same cycle; the beat is dropped.
        if (load_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        shadow_d[0] = coef_if.coef_data;
                        if (coef_if.coef_last) begin
                            err_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d   = tap_idx_t'(1);
                            state_d = LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (beat) begin
                        shadow_d[cnt_q] = coef_if.coef_data;
                        if (cnt_q == LAST_TAP) begin
                            cnt_d = '0;
                            if (coef_if.coef_last) begin
                                state_d = PENDING;
                            end else begin
                                // Over-length frame: word kept in shadow but never committed.
                                err_d   = 1'b1;
                                state_d = IDLE;
                            end
                        end else if (coef_if.coef_last) begin
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                PENDING: begin
                    if (swap_en) begin
                        active_d = shadow_q;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign coefficients = active_q;
    assign busy         = state_is_busy(state_q);
    assign load_done    = done_q;
    assign load_err     = err_q;

endmodule
